// File: rtl/clkgen_ctrl.sv
// Programmable clock/pulse generator: start phase, high and low times in clk cycles, glitch-free config updates.
// Optional macro CLKGEN_CTRL_ERRCHK_EN rejects zero ton/toff words instead of clamping them to 1.
module clkgen_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_phase,
    input  logic [CNT_W-1:0] cfg_ton,
    input  logic [CNT_W-1:0] cfg_toff,
    input  logic             start,
    input  logic             stop,
    output logic             clk_out,
    output logic             busy,
    output logic             period_tick,
    output logic             cfg_err
);

    // state | meaning
    // IDLE  | halted, output low, shadow copied straight to active
    // PHASE | counting the start phase before the first rising edge
    // HIGH  | output high for ton cycles
    // LOW   | output low for toff cycles; terminal cycle is the period boundary
    typedef enum logic [1:0] {IDLE, PHASE, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] act_phase, act_ton, act_toff;
    logic [CNT_W-1:0] sh_phase, sh_ton, sh_toff;
    logic             sh_pend, stop_pend;
    logic [CNT_W-1:0] eff_phase, eff_ton;
    logic [CNT_W-1:0] wr_ton, wr_toff;
    logic             xfer, word_bad, sh_load, tick, copy, stop_req;

    assign cfg_ready = !sh_pend;
    assign xfer      = cfg_valid && cfg_ready;

`ifdef CLKGEN_CTRL_ERRCHK_EN
    assign word_bad = (cfg_ton == '0) || (cfg_toff == '0);
    assign wr_ton   = cfg_ton;
    assign wr_toff  = cfg_toff;
`else
    assign word_bad = 1'b0;
    assign wr_ton   = (cfg_ton == '0) ? ONE : cfg_ton;
    assign wr_toff  = (cfg_toff == '0) ? ONE : cfg_toff;
`endif

    assign sh_load  = xfer && !word_bad;
    assign tick     = (state == LOW) && (cnt == '0);
    assign copy     = sh_pend && ((state == IDLE) || tick);
    assign stop_req = stop || stop_pend;

    // A pending word copied on this edge must also steer the counter load on this edge.
    assign eff_phase = sh_pend ? sh_phase : act_phase;
    assign eff_ton   = sh_pend ? sh_ton   : act_ton;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    if (eff_phase == '0) begin
                        state_nxt = HIGH;
                        cnt_nxt   = eff_ton - ONE;
                    end else begin
                        state_nxt = PHASE;
                        cnt_nxt   = eff_phase - ONE;
                    end
                end
            end
            PHASE: begin
                if (cnt == '0) begin
                    state_nxt = HIGH;
                    cnt_nxt   = act_ton - ONE;
                end else begin
                    cnt_nxt = cnt - ONE;
                end
            end
            HIGH: begin
                if (cnt == '0) begin
                    state_nxt = LOW;
                    cnt_nxt   = act_toff - ONE;
                end else begin
                    cnt_nxt = cnt - ONE;
                end
            end
            LOW: begin
                if (cnt == '0) begin
                    if (stop_req) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = HIGH;
                        cnt_nxt   = eff_ton - ONE;
                    end
                end else begin
                    cnt_nxt = cnt - ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_phase  <= '0;
            sh_ton    <= ONE;
            sh_toff   <= ONE;
            sh_pend   <= 1'b0;
            act_phase <= '0;
            act_ton   <= ONE;
            act_toff  <= ONE;
        end else begin
            if (sh_load) begin
                sh_phase <= cfg_phase;
                sh_ton   <= wr_ton;
                sh_toff  <= wr_toff;
                sh_pend  <= 1'b1;
            end else if (copy) begin
                sh_pend <= 1'b0;
            end
            if (copy) begin
                act_phase <= sh_phase;
                act_ton   <= sh_ton;
                act_toff  <= sh_toff;
            end
        end
    end

    // Stop requests arriving in IDLE are moot; while running they wait for the period end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stop_pend <= 1'b0;
        end else if ((state == IDLE) || (tick && stop_req)) begin
            stop_pend <= 1'b0;
        end else if (stop) begin
            stop_pend <= 1'b1;
        end
    end

    // Outputs are registered from the current state, so they trail the state by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_out     <= 1'b0;
            busy        <= 1'b0;
            period_tick <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            clk_out     <= (state == HIGH);
            busy        <= (state != IDLE);
            period_tick <= tick;
            cfg_err     <= xfer && word_bad;
        end
    end

endmodule

// File: tb/tb_clkgen_ctrl.sv
// Directed bench for clkgen_ctrl: phase/high/low timing, mid-run reconfig, stop, zero-word handling, reset.
module tb_clkgen_ctrl;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_phase = '0;
    logic [CNT_W-1:0] cfg_ton = '0;
    logic [CNT_W-1:0] cfg_toff = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             clk_out, busy, period_tick, cfg_err;

    int total = 0;
    int bad = 0;
    logic [CNT_W-1:0] nw_p, nw_t, nw_o;

    clkgen_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_phase(cfg_phase), .cfg_ton(cfg_ton), .cfg_toff(cfg_toff),
        .start(start), .stop(stop), .clk_out(clk_out), .busy(busy),
        .period_tick(period_tick), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int p, input int t, input int o, input logic exp_err);
        int n;
        cfg_phase = CNT_W'(p);
        cfg_ton   = CNT_W'(t);
        cfg_toff  = CNT_W'(o);
        cfg_valid = 1'b1;
        n = 0;
        while (!cfg_ready && n < 50) begin
            step();
            n++;
        end
        chk("cfg_ready_wait", (n < 50), 1);
        step();
        cfg_valid = 1'b0;
        chk("cfg_err", cfg_err, exp_err);
    endtask

    task automatic start_gen();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_phase(input int p);
        for (int i = 0; i < p; i++) begin
            step();
            chk("phase_clk_out", clk_out, 0);
            chk("phase_tick", period_tick, 0);
            chk("phase_busy", busy, 1);
        end
    endtask

    task automatic check_period(input int t, input int o, input int wr_at, input int stop_at);
        for (int i = 0; i < t + o; i++) begin
            if (i == wr_at) begin
                cfg_phase = nw_p;
                cfg_ton   = nw_t;
                cfg_toff  = nw_o;
                cfg_valid = 1'b1;
            end
            if (i == stop_at) stop = 1'b1;
            step();
            cfg_valid = 1'b0;
            stop      = 1'b0;
            chk("clk_out", clk_out, (i < t));
            chk("period_tick", period_tick, (i == t + o - 1));
            chk("busy", busy, 1);
            if (wr_at >= 0 && i >= wr_at)
                chk("cfg_ready_stall", cfg_ready, (i == t + o - 1));
        end
    endtask

    task automatic expect_stopped();
        step();
        chk("stop_busy_fall", busy, 0);
        chk("stop_clk_out", clk_out, 0);
        chk("stop_tick", period_tick, 0);
        repeat (3) step();
        chk("idle_busy", busy, 0);
        chk("idle_clk_out", clk_out, 0);
    endtask

    initial begin
        int n;
        #2;
        chk("rst_clk_out", clk_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tick", period_tick, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_ready", cfg_ready, 1);
        step();
        step();
        rst = 1'b0;
        step();

        // 0/1/1: toggle every cycle, tick every 2 cycles
        cfg_write(0, 1, 1, 1'b0);
        start_gen();
        repeat (3) check_period(1, 1, -1, -1);
        check_period(1, 1, -1, 0);
        expect_stopped();

        // 2/3/7 for five periods; mid-HIGH write of 4/5/5 in the fifth
        cfg_write(2, 3, 7, 1'b0);
        start_gen();
        check_phase(2);
        repeat (4) check_period(3, 7, -1, -1);
        nw_p = 16'd4; nw_t = 16'd5; nw_o = 16'd5;
        check_period(3, 7, 1, -1);
        check_period(5, 5, -1, 1);
        expect_stopped();

        // start with stop in IDLE: nothing happens
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        repeat (5) begin
            step();
            chk("ss_busy", busy, 0);
            chk("ss_clk_out", clk_out, 0);
        end

        // new phase from the mid-run write applies at this start
        start_gen();
        check_phase(4);
        check_period(5, 5, -1, 0);
        expect_stopped();

        // zero ton: clamped to 1 or rejected
`ifdef CLKGEN_CTRL_ERRCHK_EN
        cfg_write(0, 0, 2, 1'b1);
        step();
        chk("err_pulse_end", cfg_err, 0);
        chk("err_ready", cfg_ready, 1);
        start_gen();
        check_phase(4);
        check_period(5, 5, -1, 0);
`else
        cfg_write(0, 0, 2, 1'b0);
        start_gen();
        check_period(1, 2, -1, -1);
        check_period(1, 2, -1, 0);
`endif
        expect_stopped();

        // async reset while clk_out high
        start_gen();
        n = 0;
        while (!clk_out && n < 20) begin
            step();
            n++;
        end
        chk("rise_seen", (n < 20), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_clk_out", clk_out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_tick", period_tick, 0);
        chk("arst_ready", cfg_ready, 1);
        step();
        rst = 1'b0;
        step();
        start_gen();
        check_period(1, 1, -1, -1);
        check_period(1, 1, -1, 0);
        expect_stopped();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
